dmem_responder: RTL and testbench
=================================

# dmem_responder

Multi-cycle data-memory responder serving the processor's load/store port over a valid/ready request/response handshake. It is the responding end of the datapath's data-memory interface: it accepts one access (address, funct3 size/sign, write flag, store data), waits a configurable number of cycles, then commits the store or returns the aligned, sign- or zero-extended load data. It replaces the combinational memory with a timing-realistic slave, so the stalling front end can be developed against it.

## Interface
- ADDR_W, 8, byte-address width; storage is 2^ADDR_W bytes, organised as 2^(ADDR_W-2) 32-bit little-endian words
- WAIT_CYCLES, 2, extra wait states before the access commits; legal range 0..15
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 access size/sign
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal access

## Operation
- FSM states: IDLE, BUSY, RESP. Reset state IDLE.
- IDLE: req_ready=1. On req_valid&&req_ready, latch write/funct3/addr/wdata, load wait counter with WAIT_CYCLES, go BUSY.
- BUSY: req_ready=0. Counter decrements each cycle; in the cycle the counter is 0, the access commits on that edge (store written, load data and err registered) and the FSM goes RESP.
- RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_valid&&rsp_ready, then IDLE. No request accepted in the same cycle as a response handshake.
- Legal loads: funct3 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other funct3 -> err.
- Alignment: halfword requires addr[0]=0; word requires addr[1:0]=0; violation -> err. Aligned accesses never cross a word, so no wrap-around case exists.
- On err: no write, rsp_rdata=0, rsp_err=1.
- Load lane select by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend.
- Store: SB writes wdata[7:0] to one byte; SH wdata[15:0] to two bytes; SW all four; other bytes untouched.
- Request inputs are sampled only on the accept handshake; they are ignored in BUSY/RESP.

## Timing
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
- Latency: accept at edge N -> rsp_valid high after edge N+1+WAIT_CYCLES.
- Minimum throughput: one transaction per WAIT_CYCLES+3 cycles with rsp_ready held high.
- Reset asserted mid-operation: FSM to IDLE immediately, outputs to reset values, and an uncommitted store is dropped. Storage contents are not affected by reset.
- A store committed before reset remains in storage.

## Structure
- Shared constants file (alongside the existing defines): funct3 encodings F3_B/H/W/BU/HU and FSM state encodings.
- One combinational sub-module, dmem_load_align: inputs word, addr[1:0], funct3; output extended 32-bit result. It is reusable by the existing memory.
- Storage is a byte-lane-enabled word array inside dmem_responder.

## Test plan
- SW 0xDEADBEEF @0x10, then LW @0x10 -> rdata 0xDEADBEEF, err 0. With WAIT_CYCLES=2, rsp_valid rises exactly 3 edges after the accept edge.
- After the above: LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD; LHU @0x10 -> 0x0000BEEF.
- SB 0x55 @0x11, then LW @0x10 -> 0xDEAD55EF. SH 0xA5A5 @0x12, then LW @0x10 -> 0xA5A555EF.
- LW @0x12 -> err 1, rdata 0. SH @0x11 -> err 1, then LW @0x10 is unchanged. Load with funct3 011 -> err 1.
- Hold rsp_ready low 5 cycles in RESP -> rsp_valid, rsp_rdata and rsp_err stable, req_ready 0, and a pulsed req_valid is not accepted.
- Assert rst during BUSY of SW 0x12345678 @0x20 (previous content 0) -> outputs return to reset values at once; a subsequent LW @0x20 returns 0.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: funct3 encodings, FSM states and access legality helper
package dmem_responder_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    // Illegal funct3 for the access type, or a halfword/word access off its natural alignment
    function automatic logic access_err(input logic write, input logic [2:0] f3, input logic [1:0] a);
        logic legal;
        logic misaligned;
        legal = write ? (f3 == F3_B || f3 == F3_H || f3 == F3_W)
                      : (f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
        misaligned = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a != 2'b00);
        return !legal || misaligned;
    endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: selects the addressed lane of a word and sign/zero-extends it
module dmem_load_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] sh;

    // Shift the addressed lane down to bit 0, then extend by access size/sign
    always_comb begin
        sh = word >> {addr, 3'b000};
        data = funct3 == F3_B  ? {{24{sh[7]}}, sh[7:0]}   :
               funct3 == F3_BU ? {24'h0, sh[7:0]}         :
               funct3 == F3_H  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == F3_HU ? {16'h0, sh[15:0]}        :
               sh;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle valid/ready data-memory slave with byte-lane storage
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int WORDS = 2 ** (ADDR_W - 2);

    state_t            state, state_nx;
    logic [3:0]        cnt;
    logic              wr_q;
    logic [2:0]        f3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic [31:0]       mem [WORDS];
    logic [ADDR_W-3:0] idx;
    logic              accept;
    logic              commit;
    logic              err_c;
    logic [3:0]        be;
    logic [31:0]       wd;
    logic [31:0]       load_c;

    assign idx       = addr_q[ADDR_W-1:2];
    assign accept    = req_valid && state == IDLE;
    assign commit    = state == BUSY && cnt == 4'd0;
    assign err_c     = access_err(wr_q, f3_q, addr_q[1:0]);
    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

    dmem_load_align u_align (
        .word   (mem[idx]),
        .addr   (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_c)
    );

    // Next state: accept in IDLE, commit when the wait counter reaches zero, leave RESP on handshake
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = req_valid ? BUSY : IDLE;
            BUSY:    state_nx = cnt == 4'd0 ? RESP : BUSY;
            RESP:    state_nx = rsp_ready ? IDLE : RESP;
            default: state_nx = IDLE;
        endcase
    end

    // Store byte enables and lane-aligned write data
    always_comb begin
        be = f3_q[1:0] == 2'b00 ? 4'b0001 << addr_q[1:0] :
             f3_q[1:0] == 2'b01 ? 4'b0011 << addr_q[1:0] : 4'b1111;
        wd = wdata_q << {addr_q[1:0], 3'b000};
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Request capture, wait counter and registered response
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= 4'd0;
            wr_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            if (accept) begin
                cnt     <= 4'(WAIT_CYCLES);
                wr_q    <= req_write;
                f3_q    <= req_funct3;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end else if (state == BUSY && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rdata_q <= (err_c || wr_q) ? 32'd0 : load_c;
                err_q   <= err_c;
            end
        end
    end

    // Storage is not reset; a store commits only on its final BUSY edge
    always_ff @(posedge clk) begin
        if (commit && wr_q && !err_c && rst)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[idx][i*8 +: 8] <= wd[i*8 +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed self-checking bench for dmem_responder
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [7:0]  req_addr = 8'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int total = 0;
    int bad = 0;
    int lat;
    logic [31:0] rd;
    logic        er;

    dmem_responder #(.ADDR_W(8), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0; req_wdata = 32'hCAFEF00D; req_addr = 8'hFC;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("rsp_seen", {31'd0, rsp_valid}, 32'd1);
    endtask

    task automatic ack();
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic txn(input logic w, input logic [2:0] f3, input logic [7:0] a, input logic [31:0] d,
                       output logic [31:0] r, output logic e);
        int n;
        send(w, f3, a, d);
        wait_rsp(n);
        lat = n;
        r = rsp_rdata;
        e = rsp_err;
        ack();
    endtask

    initial begin
        #2;
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'd0);
        check("rst_err", {31'd0, rsp_err}, 32'd0);
        @(negedge clk); rst = 1'b1;

        txn(1'b1, 3'b010, 8'h10, 32'hDEADBEEF, rd, er);
        check("sw_rdata", rd, 32'd0);
        check("sw_err", {31'd0, er}, 32'd0);
        txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er);
        check("lw_rdata", rd, 32'hDEADBEEF);
        check("lw_err", {31'd0, er}, 32'd0);
        check("lw_latency", lat, 32'd3);

        txn(1'b0, 3'b000, 8'h13, 32'd0, rd, er); check("lb_13", rd, 32'hFFFFFFDE);
        txn(1'b0, 3'b100, 8'h13, 32'd0, rd, er); check("lbu_13", rd, 32'h000000DE);
        txn(1'b0, 3'b001, 8'h12, 32'd0, rd, er); check("lh_12", rd, 32'hFFFFDEAD);
        txn(1'b0, 3'b101, 8'h10, 32'd0, rd, er); check("lhu_10", rd, 32'h0000BEEF);

        txn(1'b1, 3'b000, 8'h11, 32'hFFFFFF55, rd, er);
        txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er); check("sb_then_lw", rd, 32'hDEAD55EF);
        txn(1'b1, 3'b001, 8'h12, 32'hFFFFA5A5, rd, er);
        txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er); check("sh_then_lw", rd, 32'hA5A555EF);

        txn(1'b0, 3'b010, 8'h12, 32'd0, rd, er);
        check("lw_mis_err", {31'd0, er}, 32'd1);
        check("lw_mis_rdata", rd, 32'd0);
        txn(1'b1, 3'b001, 8'h11, 32'h00001234, rd, er);
        check("sh_mis_err", {31'd0, er}, 32'd1);
        txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er); check("sh_mis_nowrite", rd, 32'hA5A555EF);
        txn(1'b0, 3'b011, 8'h10, 32'd0, rd, er);
        check("f3_011_err", {31'd0, er}, 32'd1);
        check("f3_011_rdata", rd, 32'd0);
        txn(1'b1, 3'b100, 8'h10, 32'h0, rd, er);
        check("st_f3_100_err", {31'd0, er}, 32'd1);

        send(1'b0, 3'b010, 8'h10, 32'd0);
        wait_rsp(lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); req_valid = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 32'h0;
            #1;
            check("hold_valid", {31'd0, rsp_valid}, 32'd1);
            check("hold_rdata", rsp_rdata, 32'hA5A555EF);
            check("hold_err", {31'd0, rsp_err}, 32'd0);
            check("hold_req_ready", {31'd0, req_ready}, 32'd0);
            @(posedge clk); #1; req_valid = 1'b0;
        end
        ack();
        #1;
        check("post_hold_idle", {31'd0, req_ready}, 32'd1);
        txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er); check("pulse_not_accepted", rd, 32'hA5A555EF);

        txn(1'b1, 3'b010, 8'h20, 32'h0, rd, er);
        txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er); check("pre_rst_lw", rd, 32'hA5A555EF);
        send(1'b1, 3'b010, 8'h20, 32'h12345678);
        @(negedge clk); rst = 1'b0;
        #1;
        check("midrst_req_ready", {31'd0, req_ready}, 32'd1);
        check("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("midrst_rdata", rsp_rdata, 32'd0);
        check("midrst_err", {31'd0, rsp_err}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        txn(1'b0, 3'b010, 8'h20, 32'd0, rd, er); check("dropped_store", rd, 32'd0);
        txn(1'b0, 3'b010, 8'h10, 32'd0, rd, er); check("kept_store", rd, 32'hA5A555EF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
